axis_rx_frame_sink: RTL
=======================

Name: axis_rx_frame_sink

Overview:
- AXI-Stream receive-side sink for the LMAC RX path. It is the consumer end of the rx_axis_mac_* interface that the LMAC drives.
- Generates tready, including programmable backpressure patterns, and accumulates per-frame byte counts from tstrb.
- Checks strobe legality, length bounds and the tuser error flag, and cross-checks the frame length against rx_statistics_vector.
- Reports per-frame results plus saturating frame and error counters to the bench/host.

Parameters:
- DATA_WIDTH, 64, rx data width in bits.
- STRB_WIDTH, 8, DATA_WIDTH/8.
- BCNT_WIDTH, 16, frame byte-count width.
- MIN_FRAME, 60, minimum legal length in bytes, excluding FCS.
- MAX_FRAME, 1518, maximum legal length in bytes.
- STAT_TIMEOUT, 16, cycles to wait after tlast for rx_statistics_valid.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- rx_axis_mac_tdata  in  DATA_WIDTH  receive data.
- rx_axis_mac_tvalid  in  1  beat valid.
- rx_axis_mac_tlast  in  1  last beat of frame.
- rx_axis_mac_tuser  in  1  MAC error flag; sampled on the tlast beat.
- rx_axis_mac_tstrb  in  STRB_WIDTH  valid-byte mask.
- rx_axis_mac_tready  out  1  sink ready.
- rx_statistics_vector  in  28  bits [18:5] = frame length.
- rx_statistics_valid  in  1  statistics strobe.
- sink_en  in  1  enables acceptance.
- bp_mode  in  2  backpressure mode.
- frm_done  out  1  one-cycle pulse per completed frame.
- frm_len  out  BCNT_WIDTH  byte count of last frame.
- frm_err  out  4  {stat_mismatch, len_err, strb_err, tuser_err}.
- frm_cnt  out  32  frames completed, saturating.
- err_cnt  out  32  frames with any frm_err bit set, saturating.

Behaviour:
- Reset: all outputs 0; FSM IDLE; LFSR = 16'hACE1; accumulators cleared. Reset mid-frame discards the frame with no frm_done.
- Beat accept: tvalid && tready. tready is registered; its value for cycle n+1 is computed in cycle n.
- bp_mode:
  - 00: tready=1.
  - 01: tready toggles every cycle, starting at 1.
  - 10: tready = LFSR[0]; the LFSR is Fibonacci x^16+x^14+x^13+x^11+1 and shifts every cycle.
  - 11: tready=0.
  - Modes apply only in IDLE (with sink_en=1) and RECV. tready=0 in STAT_WAIT and REPORT.
- FSM:
  - IDLE: on the first accepted beat go to RECV. That beat also goes to STAT_WAIT if it carries tlast.
  - RECV: on an accepted beat with tlast, go to STAT_WAIT.
  - STAT_WAIT: go to REPORT when the statistics have been latched or the timer reaches STAT_TIMEOUT.
  - REPORT: pulse frm_done, update frm_len, frm_err and the counters, then return to IDLE.
- If sink_en falls mid-frame, the frame is still completed. IDLE then holds tready=0.
- Byte count: add the popcount of tstrb per accepted beat. The count saturates at 2^BCNT_WIDTH-1.
- strb_err is set by either of:
  - a non-tlast beat with tstrb != all-ones;
  - a tlast beat whose tstrb is zero or not of the form 2^k-1 (bytes not contiguous from bit 0).
- len_err: final count < MIN_FRAME or > MAX_FRAME.
- tuser_err: tuser=1 on the tlast beat.
- Statistics capture: the first rx_statistics_valid seen in RECV or STAT_WAIT latches bits [18:5]. A strobe on the same cycle as the tlast beat counts. Strobes in IDLE or REPORT are ignored.
- stat_mismatch: latched length != byte count, or timeout with nothing latched.
- Counters: frm_cnt += 1 per REPORT. err_cnt += 1 if frm_err != 0. Both hold at 32'hFFFFFFFF.
- frm_len and frm_err hold until the next REPORT.
- Latency: frm_done asserts 2 cycles after the tlast beat when statistics arrive with tlast.

Optional Feature:
- Macro: AXIS_SINK_CRC_EN.
- Defined: adds output frm_crc [31:0], updated at REPORT. It is the Ethernet CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over the valid bytes in order, byte 0 = tdata[7:0].
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- bp_mode=00, 64-byte frame: 8 beats of tstrb FF, stats length 64 with tlast -> frm_done 2 cycles after tlast, frm_len=64, frm_err=0, frm_cnt=1.
- bp_mode=01, 61-byte frame (last tstrb 8'h1F), no statistics strobe -> frm_done 16 cycles after tlast, frm_len=61, frm_err=4'b1000, err_cnt=1.
- bp_mode=10, 1519-byte frame with matching stats -> len_err set, frm_err=4'b0100; tready sequence matches an LFSR model seeded 16'hACE1.
- Middle beat tstrb=8'h7F, tlast beat tstrb=8'h05, tuser=1 -> frm_err=4'b0011 plus len_err if short; frm_cnt and err_cnt each increment by 1.
- reset_ low after beat 3 of a frame -> all outputs 0 immediately; no frm_done. The next clean 64-byte frame gives frm_cnt=1.
- AXIS_SINK_CRC_EN defined, 9-byte frame "123456789" -> frm_crc=32'hCBF43926, len_err=1.

Source files
------------

// File: rtl/axis_rx_frame_sink.sv
// axis_rx_frame_sink
// Consumer end of the LMAC rx_axis_mac_* stream. Drives tready with a
// selectable backpressure pattern, counts frame bytes from tstrb, flags
// strobe / length / tuser errors, cross-checks the length reported on
// rx_statistics_vector and keeps saturating frame and error counters.
// Optional feature: define AXIS_SINK_CRC_EN to add frm_crc, the Ethernet
// CRC-32 of each received frame.
module axis_rx_frame_sink #(
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int BCNT_WIDTH   = 16,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1518,
  parameter int STAT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
  input  logic                  rx_axis_mac_tvalid,
  input  logic                  rx_axis_mac_tlast,
  input  logic                  rx_axis_mac_tuser,
  input  logic [STRB_WIDTH-1:0] rx_axis_mac_tstrb,
  output logic                  rx_axis_mac_tready,
  input  logic [27:0]           rx_statistics_vector,
  input  logic                  rx_statistics_valid,
  input  logic                  sink_en,
  input  logic [1:0]            bp_mode,
  output logic                  frm_done,
  output logic [BCNT_WIDTH-1:0] frm_len,
  output logic [3:0]            frm_err,
  output logic [31:0]           frm_cnt,
  output logic [31:0]           err_cnt
`ifdef AXIS_SINK_CRC_EN
  ,
  output logic [31:0]           frm_crc
`endif
);

  localparam int PC_W  = $clog2(STRB_WIDTH + 1);
  localparam int TMR_W = $clog2(STAT_TIMEOUT + 1);
  // Leaving STAT_WAIT when the timer shows STAT_TIMEOUT-1 puts REPORT
  // exactly STAT_TIMEOUT cycles after the tlast beat.
  localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(STAT_TIMEOUT - 1);
  localparam logic [BCNT_WIDTH-1:0] MIN_LEN  = BCNT_WIDTH'(MIN_FRAME);
  localparam logic [BCNT_WIDTH-1:0] MAX_LEN  = BCNT_WIDTH'(MAX_FRAME);
  localparam logic [15:0]           LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECV      = 2'd1,
    S_STAT_WAIT = 2'd2,
    S_REPORT    = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    tready_d;
  logic                    rdy_en;
  logic                    rdy_pat;
  logic                    accept;
  logic                    go_report;
  logic [15:0]             lfsr_q;
  logic                    lfsr_fb;
  logic [TMR_W-1:0]        timer_q;
  logic [BCNT_WIDTH-1:0]   bcnt_q;
  logic                    strb_err_q;
  logic                    tuser_err_q;
  logic                    stat_hit_q;
  logic [13:0]             stat_len_q;
  logic                    stat_mis;
  logic                    len_err;
  logic [3:0]              frm_err_d;
  logic                    stat_window;

  // Bits of the statistics vector other than the length field are not used.
  logic unused_stat;
  assign unused_stat = ^{rx_statistics_vector[27:19], rx_statistics_vector[4:0]};

  // Number of valid bytes flagged in a strobe mask.
  function automatic logic [PC_W-1:0] popcount(input logic [STRB_WIDTH-1:0] s);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      n = n + PC_W'(s[i]);
    end
    return n;
  endfunction

  // Non-last beats must be full; the last beat must be non-empty and
  // contiguous from byte 0 (mask of the form 2^k-1).
  function automatic logic strb_bad(input logic [STRB_WIDTH-1:0] s, input logic last);
    logic [STRB_WIDTH-1:0] s_inc;
    s_inc = s + STRB_WIDTH'(1);
    if (!last) begin
      return s != '1;
    end
    return (s == '0) || ((s & s_inc) != '0);
  endfunction

  // Byte counter addition that sticks at all-ones.
  function automatic logic [BCNT_WIDTH-1:0] bcnt_add(input logic [BCNT_WIDTH-1:0] acc,
                                                      input logic [PC_W-1:0]       inc);
    logic [BCNT_WIDTH:0] sum;
    sum = {1'b0, acc} + (BCNT_WIDTH + 1)'(inc);
    return sum[BCNT_WIDTH] ? '1 : sum[BCNT_WIDTH-1:0];
  endfunction

  // 32-bit counter increment that holds at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign accept      = rx_axis_mac_tvalid && rx_axis_mac_tready;
  assign lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign stat_window = (state_q == S_RECV) || (state_q == S_STAT_WAIT);

  // Next state and next tready value, computed one cycle ahead of use.
  always_comb begin
    state_d   = state_q;
    go_report = 1'b0;
    rdy_pat   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = rx_axis_mac_tlast ? S_STAT_WAIT : S_RECV;
        end
      end
      S_RECV: begin
        if (accept && rx_axis_mac_tlast) begin
          state_d = S_STAT_WAIT;
        end
      end
      S_STAT_WAIT: begin
        if (stat_hit_q || (timer_q == TMR_LAST)) begin
          state_d   = S_REPORT;
          go_report = 1'b1;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    case (bp_mode)
      2'b00:   rdy_pat = 1'b1;
      2'b01:   rdy_pat = ~rx_axis_mac_tready;
      2'b10:   rdy_pat = lfsr_q[0];
      default: rdy_pat = 1'b0;
    endcase
    rdy_en   = (state_d == S_RECV) || ((state_d == S_IDLE) && sink_en);
    tready_d = rdy_en && rdy_pat;
  end

  // Per-frame verdict, valid while STAT_WAIT decides to report.
  always_comb begin
    stat_mis  = !stat_hit_q || (BCNT_WIDTH'(stat_len_q) != bcnt_q);
    len_err   = (bcnt_q < MIN_LEN) || (bcnt_q > MAX_LEN);
    frm_err_d = {stat_mis, len_err, strb_err_q, tuser_err_q};
  end

  // FSM state, registered tready and the free-running backpressure LFSR.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q            <= S_IDLE;
      rx_axis_mac_tready <= 1'b0;
      lfsr_q             <= LFSR_SEED;
    end else begin
      state_q            <= state_d;
      rx_axis_mac_tready <= tready_d;
      lfsr_q             <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  // Frame accumulators: byte count, sticky error flags, statistics latch
  // and the post-tlast timer; all cleared once the frame is reported.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bcnt_q      <= '0;
      strb_err_q  <= 1'b0;
      tuser_err_q <= 1'b0;
      stat_hit_q  <= 1'b0;
      stat_len_q  <= '0;
      timer_q     <= '0;
    end else if (state_q == S_REPORT) begin
      bcnt_q      <= '0;
      strb_err_q  <= 1'b0;
      tuser_err_q <= 1'b0;
      stat_hit_q  <= 1'b0;
      stat_len_q  <= '0;
      timer_q     <= '0;
    end else begin
      if (accept) begin
        bcnt_q <= bcnt_add(bcnt_q, popcount(rx_axis_mac_tstrb));
        if (strb_bad(rx_axis_mac_tstrb, rx_axis_mac_tlast)) begin
          strb_err_q <= 1'b1;
        end
        if (rx_axis_mac_tlast) begin
          tuser_err_q <= rx_axis_mac_tuser;
          timer_q     <= TMR_W'(1);
        end
      end
      if (state_q == S_STAT_WAIT) begin
        timer_q <= timer_q + TMR_W'(1);
      end
      if (stat_window && rx_statistics_valid && !stat_hit_q) begin
        stat_hit_q <= 1'b1;
        stat_len_q <= rx_statistics_vector[18:5];
      end
    end
  end

  // Report registers: one-cycle done pulse, held results, saturating counters.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      frm_done <= 1'b0;
      frm_len  <= '0;
      frm_err  <= '0;
      frm_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      frm_done <= go_report;
      if (go_report) begin
        frm_len <= bcnt_q;
        frm_err <= frm_err_d;
        frm_cnt <= sat_inc(frm_cnt);
        if (frm_err_d != 4'b0000) begin
          err_cnt <= sat_inc(err_cnt);
        end
      end
    end
  end

`ifdef AXIS_SINK_CRC_EN
  logic [31:0] crc_q;

  // Reflected CRC-32 (poly 0x04C11DB7 as 0xEDB88320) over one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Fold every strobed byte of a beat into the CRC, byte 0 first.
  function automatic logic [31:0] crc32_beat(input logic [31:0]           c_in,
                                             input logic [DATA_WIDTH-1:0] d,
                                             input logic [STRB_WIDTH-1:0] s);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (s[i]) begin
        c = crc32_byte(c, d[8*i +: 8]);
      end
    end
    return c;
  endfunction

  // Running CRC per frame and the final inverted value published at report.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      crc_q   <= 32'hFFFF_FFFF;
      frm_crc <= '0;
    end else begin
      if (state_q == S_REPORT) begin
        crc_q <= 32'hFFFF_FFFF;
      end else if (accept) begin
        crc_q <= crc32_beat(crc_q, rx_axis_mac_tdata, rx_axis_mac_tstrb);
      end
      if (go_report) begin
        frm_crc <= ~crc_q;
      end
    end
  end
`else
  // Data bytes only feed the CRC, which is absent in this build.
  logic unused_data;
  assign unused_data = ^rx_axis_mac_tdata;
`endif

endmodule
